// File: rtl/tanh_share_scheduler.sv
// Round-robin sharing of one registered tanh unit between N requesters.
// Each requester has one operation in flight and a result slot held until consumed.
module tanh_share_scheduler #(
  parameter int N           = 4,
  parameter int DW          = 8,
  parameter int ACT_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic [DW-1:0]   act_x,
  input  logic [DW-1:0]   act_y,
  output logic [N-1:0]    rsp_valid,
  output logic [N*DW-1:0] rsp_data,
  input  logic [N-1:0]    rsp_ready
);

  localparam int IW = $clog2(N);

  logic [IW-1:0]          ptr_q, ptr_d;
  logic [N-1:0]           busy_q, busy_d;
  logic [ACT_LATENCY-1:0] tag_v_q, tag_v_d;
  logic [IW-1:0]          tag_id_q [ACT_LATENCY];
  logic [IW-1:0]          tag_id_d [ACT_LATENCY];
  logic [N-1:0]           rsp_valid_q, rsp_valid_d;
  logic [N*DW-1:0]        rsp_data_q, rsp_data_d;

  logic [N-1:0]  elig, grant, rsp_fire;
  logic          accept;
  logic [IW-1:0] gnt_idx, cand;

  // Busy covers the whole lifetime of an operation, so grants never depend on rsp_ready.
  assign elig     = req_valid & ~busy_q;
  assign rsp_fire = rsp_valid_q & rsp_ready;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    grant   = '0;
    accept  = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    act_x   = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!accept && elig[cand]) begin
        accept      = 1'b1;
        grant[cand] = 1'b1;
        gnt_idx     = cand;
      end
    end
    if (accept) act_x = req_data[gnt_idx*DW +: DW];
  end

  always_comb begin
    busy_d      = (busy_q & ~rsp_fire) | grant;
    ptr_d       = accept ? IW'((int'(gnt_idx) + 1) % N) : ptr_q;
    tag_v_d[0]  = accept;
    tag_id_d[0] = gnt_idx;
    for (int s = 1; s < ACT_LATENCY; s++) begin
      tag_v_d[s]  = tag_v_q[s-1];
      tag_id_d[s] = tag_id_q[s-1];
    end
    rsp_valid_d = rsp_valid_q & ~rsp_fire;
    rsp_data_d  = rsp_data_q;
    // The slot being written is busy, so it cannot also be handshaking this cycle.
    if (tag_v_q[ACT_LATENCY-1]) begin
      rsp_valid_d[tag_id_q[ACT_LATENCY-1]]               = 1'b1;
      rsp_data_d[tag_id_q[ACT_LATENCY-1]*DW +: DW]       = act_y;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      busy_q      <= '0;
      tag_v_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      // NOTE: tag ids are reset as well; the array is tiny and this keeps X off the slot index.
      for (int s = 0; s < ACT_LATENCY; s++) tag_id_q[s] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      tag_v_q     <= tag_v_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      for (int s = 0; s < ACT_LATENCY; s++) tag_id_q[s] <= tag_id_d[s];
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_tanh_share_scheduler.sv
// Bench for tanh_share_scheduler: directed scenarios plus a randomized run
// against a transaction-level model of grants, tags and response slots.
module tb_tanh_share_scheduler;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int LAT = 1;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*DW-1:0] req_data, rsp_data;
  logic [DW-1:0]   act_x, act_y;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tanh_share_scheduler #(.N(N), .DW(DW), .ACT_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .act_x(act_x), .act_y(act_y),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  // Stand-in tanh: pinned at the characterised points, linear-clamped elsewhere.
  function automatic logic [DW-1:0] tanh_model(input logic [DW-1:0] x);
    int v;
    case (x)
      8'h28:   return 8'd105;
      8'h64:   return 8'd127;
      8'h80:   return 8'h80;
      default: begin
        v = 4 * int'($signed(x));
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return DW'(v);
      end
    endcase
  endfunction

  // Registered tanh unit sharing the scheduler's reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) act_y <= '0;
    else        act_y <= tanh_model(act_x);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = '0;
    req_data  = '0;
    rsp_ready = '0;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    #1 reset = 1'b0;
    settle();
    n_checks++; if (req_ready !== '0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else n_pass++;
    n_checks++; if (act_x !== '0) $display("FAIL reset_act_x: got %h want 0", act_x); else n_pass++;
    n_checks++; if (rsp_valid !== '0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== '0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else n_pass++;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_single_op();
    logic [DW-1:0] xs [3] = '{8'h28, 8'h64, 8'h80};
    logic [DW-1:0] ys [3] = '{8'd105, 8'd127, 8'h80};
    logic [N-1:0]  e;
    for (int k = 0; k < 3; k++) begin
      e = '0; e[k] = 1'b1;
      tick(); idle(); req_valid[k] = 1'b1; req_data[k*DW +: DW] = xs[k]; settle();
      n_checks++; if (req_ready !== e) $display("FAIL single_grant r=%0d: got %b want %b", k, req_ready, e); else n_pass++;
      n_checks++; if (act_x !== xs[k]) $display("FAIL single_act_x r=%0d: got %h want %h", k, act_x, xs[k]); else n_pass++;
      tick(); idle(); settle();
      n_checks++; if (rsp_valid !== '0) $display("FAIL single_early r=%0d: got %b want 0", k, rsp_valid); else n_pass++;
      tick(); settle();
      n_checks++; if (rsp_valid !== e) $display("FAIL single_rsp_valid r=%0d: got %b want %b", k, rsp_valid, e); else n_pass++;
      n_checks++; if (rsp_data[k*DW +: DW] !== ys[k])
        $display("FAIL single_rsp_data r=%0d: got %h want %h", k, rsp_data[k*DW +: DW], ys[k]); else n_pass++;
      tick(); rsp_ready[k] = 1'b1; settle();
      tick(); rsp_ready = '0; settle();
      n_checks++; if (rsp_valid !== '0) $display("FAIL single_consumed r=%0d: got %b want 0", k, rsp_valid); else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  e;
    int            g;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      g = c % N;
      e = '0; e[g] = 1'b1;
      tick(); req_valid = '1; rsp_ready = '1; req_data = (N*DW)'($urandom); settle();
      n_checks++; if (req_ready !== e) $display("FAIL rr_grant c=%0d: got %b want %b", c, req_ready, e); else n_pass++;
      n_checks++; if (act_x !== req_data[g*DW +: DW])
        $display("FAIL rr_act_x c=%0d: got %h want %h", c, act_x, req_data[g*DW +: DW]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [N*DW-1:0] d;
    logic [DW-1:0]   exp1;
    apply_reset();
    d    = (N*DW)'($urandom);
    exp1 = tanh_model(d[1*DW +: DW]);
    for (int c = 0; c < 14; c++) begin
      tick(); req_valid = '1; req_data = d; rsp_ready = 4'b1101; settle();
      if (c >= 2) begin
        n_checks++; if (req_ready[1] !== 1'b0) $display("FAIL bp_ready1 c=%0d: got %b want 0", c, req_ready[1]); else n_pass++;
        n_checks++; if (req_ready === '0) $display("FAIL bp_others_served c=%0d: got %b want nonzero", c, req_ready); else n_pass++;
      end
      if (c >= 3) begin
        n_checks++; if (rsp_valid[1] !== 1'b1) $display("FAIL bp_rsp_valid1 c=%0d: got %b want 1", c, rsp_valid[1]); else n_pass++;
        n_checks++; if (rsp_data[1*DW +: DW] !== exp1)
          $display("FAIL bp_rsp_data1 c=%0d: got %h want %h", c, rsp_data[1*DW +: DW], exp1); else n_pass++;
      end
    end
  endtask

  task automatic test_same_cycle_release();
    apply_reset();
    tick(); req_valid = 4'b0100; req_data = (N*DW)'($urandom); settle();
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL scr_accept: got %b want 0100", req_ready); else n_pass++;
    tick(); settle();
    n_checks++; if (req_ready !== '0) $display("FAIL scr_busy: got %b want 0", req_ready); else n_pass++;
    tick(); rsp_ready[2] = 1'b1; settle();
    n_checks++; if (rsp_valid[2] !== 1'b1) $display("FAIL scr_rsp_rise: got %b want 1", rsp_valid[2]); else n_pass++;
    n_checks++; if (req_ready[2] !== 1'b0) $display("FAIL scr_same_cycle: got %b want 0", req_ready[2]); else n_pass++;
    tick(); rsp_ready = '0; settle();
    n_checks++; if (rsp_valid[2] !== 1'b0) $display("FAIL scr_consumed: got %b want 0", rsp_valid[2]); else n_pass++;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL scr_next_cycle: got %b want 0100", req_ready); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    logic [DW-1:0] x3;
    apply_reset();
    tick(); req_valid = 4'b1000; req_data = (N*DW)'($urandom); settle();
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL rmf_accept3: got %b want 1000", req_ready); else n_pass++;
    tick(); req_valid = 4'b0001; settle();
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL rmf_accept0: got %b want 0001", req_ready); else n_pass++;
    tick(); idle(); reset = 1'b0; settle();
    n_checks++; if (rsp_valid !== '0) $display("FAIL rmf_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== '0) $display("FAIL rmf_rsp_data: got %h want 0", rsp_data); else n_pass++;
    tick(); reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(); settle();
      n_checks++; if (rsp_valid !== '0) $display("FAIL rmf_stale c=%0d: got %b want 0", c, rsp_valid); else n_pass++;
    end
    // Pointer back at 0 means requester 0 wins over 3.
    tick(); req_valid = 4'b1001; req_data = (N*DW)'($urandom); x3 = req_data[3*DW +: DW]; settle();
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL rmf_ptr_zero: got %b want 0001", req_ready); else n_pass++;
    tick(); req_valid = 4'b1000; settle();
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL rmf_fresh3: got %b want 1000", req_ready); else n_pass++;
    tick(); idle(); settle();
    n_checks++; if (rsp_valid !== 4'b0001) $display("FAIL rmf_rsp0: got %b want 0001", rsp_valid); else n_pass++;
    tick(); settle();
    n_checks++; if (rsp_valid !== 4'b1001) $display("FAIL rmf_rsp3: got %b want 1001", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data[3*DW +: DW] !== tanh_model(x3))
      $display("FAIL rmf_rsp3_data: got %h want %h", rsp_data[3*DW +: DW], tanh_model(x3)); else n_pass++;
  endtask

  task automatic test_fairness();
    int cnt [N];
    int free_at [N];
    int max_wait;
    int diff;
    apply_reset();
    max_wait = 0;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; free_at[i] = 0; end
    for (int c = 0; c < 100; c++) begin
      tick(); req_valid = 4'b0101; rsp_ready = '1; req_data = (N*DW)'($urandom); settle();
      n_checks++; if ((req_ready & 4'b1010) !== '0) $display("FAIL fair_invalid_grant c=%0d: got %b", c, req_ready); else n_pass++;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          cnt[i]++;
          if (c - free_at[i] > max_wait) max_wait = c - free_at[i];
          free_at[i] = c + LAT + 2;
        end
      end
    end
    diff = cnt[0] - cnt[2];
    if (diff < 0) diff = -diff;
    n_checks++; if ((diff <= 1) !== 1'b1) $display("FAIL fair_counts: got %0d vs %0d want diff<=1", cnt[0], cnt[2]); else n_pass++;
    n_checks++; if ((max_wait <= N) !== 1'b1) $display("FAIL fair_wait: got %0d want <=%0d", max_wait, N); else n_pass++;
    n_checks++; if ((cnt[0] + cnt[2] >= 60) !== 1'b1) $display("FAIL fair_throughput: got %0d want >=60", cnt[0] + cnt[2]); else n_pass++;
  endtask

  // Model: each requester is idle or owns one operation whose result shows up
  // LAT+1 cycles after acceptance and stays until consumed.
  task automatic test_random();
    bit            busy [N];
    int            rdy_at [N];
    logic [DW-1:0] exp_d [N];
    int            ptr, eg, idx, accepts;
    logic [N-1:0]  e_ready, e_rv;
    logic [DW-1:0] e_x;
    apply_reset();
    ptr = 0; accepts = 0;
    for (int i = 0; i < N; i++) begin busy[i] = 1'b0; rdy_at[i] = 0; exp_d[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      tick();
      req_valid = N'($urandom);
      req_data  = (N*DW)'($urandom);
      rsp_ready = N'($urandom);
      settle();
      eg = -1;
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        if (eg < 0 && req_valid[idx] && !busy[idx]) eg = idx;
      end
      e_ready = '0;
      e_x     = '0;
      if (eg >= 0) begin e_ready[eg] = 1'b1; e_x = req_data[eg*DW +: DW]; end
      for (int i = 0; i < N; i++) e_rv[i] = busy[i] && (c >= rdy_at[i]);
      n_checks++; if (req_ready !== e_ready) $display("FAIL rnd_grant c=%0d: got %b want %b", c, req_ready, e_ready); else n_pass++;
      n_checks++; if (act_x !== e_x) $display("FAIL rnd_act_x c=%0d: got %h want %h", c, act_x, e_x); else n_pass++;
      n_checks++; if (rsp_valid !== e_rv) $display("FAIL rnd_rsp_valid c=%0d: got %b want %b", c, rsp_valid, e_rv); else n_pass++;
      for (int i = 0; i < N; i++) begin
        if (e_rv[i]) begin
          n_checks++; if (rsp_data[i*DW +: DW] !== exp_d[i])
            $display("FAIL rnd_rsp_data c=%0d i=%0d: got %h want %h", c, i, rsp_data[i*DW +: DW], exp_d[i]); else n_pass++;
          if (rsp_ready[i]) busy[i] = 1'b0;
        end
      end
      if (eg >= 0) begin
        busy[eg]   = 1'b1;
        exp_d[eg]  = tanh_model(req_data[eg*DW +: DW]);
        rdy_at[eg] = c + LAT + 1;
        ptr        = (eg + 1) % N;
        accepts++;
      end
    end
    n_checks++; if ((accepts > 50) !== 1'b1) $display("FAIL rnd_activity: got %0d accepts want >50", accepts); else n_pass++;
  endtask

  initial begin
    idle();
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_same_cycle_release();
    test_reset_midflight();
    test_fairness();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
